pc_gen: RTL

//  Parametrised program-counter generator for the IF stage; successor to the fixed-width PC register.

---
 rtl/pc_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage. It holds the word-aligned fetch PC and
// presents it to instruction memory over a valid/ready handshake. The next PC is chosen
// with the priority exception > redirect > sequential. The block also provides a boot
// delay, halt/resume, capture of redirects that arrive while not running, and saturating
// performance counters.
module pc_gen #(
    parameter int unsigned          ADDR_W     = 30,
    parameter logic [ADDR_W-1:0]    RESET_VEC  = ADDR_W'(30'h0000BFF),
    parameter logic [ADDR_W-1:0]    EXC_VEC    = ADDR_W'(30'h0000040),
    parameter int unsigned          BOOT_DELAY = 2,
    parameter int unsigned          CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_write_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              exc_i,
    input  logic              halt_i,
    input  logic              fetch_ready_i,
    input  logic              cnt_clr_i,
    output logic              fetch_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W+1:0] pc_byte_o,
    output logic              pending_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  fetch_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int unsigned BOOT_W = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_DELAY);

    typedef enum logic [1:0] {
        StBoot = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                pend_q, pend_d;
    logic                pend_exc_q, pend_exc_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]    fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic                fetch_valid;
    logic                advance;
    // Pending capture including this cycle's request, so a request arriving on the
    // resume cycle itself is still honoured when entering RUN.
    logic                pend_merge;
    logic                pend_exc_merge;
    logic [ADDR_W-1:0]   pend_pc_merge;

    assign fetch_valid = (state_q == StRun);
    assign advance     = fetch_valid & fetch_ready_i & pc_write_i;

    // Merge a new exception/redirect into the captured pending target.
    always_comb begin
        pend_merge     = pend_q;
        pend_exc_merge = pend_exc_q;
        pend_pc_merge  = pend_pc_q;
        if (exc_i) begin
            pend_merge     = 1'b1;
            pend_exc_merge = 1'b1;
            pend_pc_merge  = EXC_VEC;
        end else if (redirect_i && !(pend_q && pend_exc_q)) begin
            // A redirect never displaces a pending exception.
            pend_merge     = 1'b1;
            pend_exc_merge = 1'b0;
            pend_pc_merge  = redirect_pc_i;
        end
    end

    // Next-state, next-PC and pending-capture logic.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_exc_d = pend_exc_q;
        pend_pc_d  = pend_pc_q;
        unique case (state_q)
            StBoot: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = StRun;
                    pend_d     = 1'b0;
                    pend_exc_d = 1'b0;
                    if (pend_merge) begin
                        pc_d = pend_pc_merge;
                    end
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                    pend_d     = pend_merge;
                    pend_exc_d = pend_exc_merge;
                    pend_pc_d  = pend_pc_merge;
                end
            end
            StRun: begin
                if (exc_i) begin
                    pc_d = EXC_VEC;
                end else if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end else if (advance && !halt_i) begin
                    // Wraps modulo 2^ADDR_W by construction.
                    pc_d = pc_q + ADDR_W'(1);
                end
                if (halt_i) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!halt_i) begin
                    state_d    = StRun;
                    pend_d     = 1'b0;
                    pend_exc_d = 1'b0;
                    if (pend_merge) begin
                        pc_d = pend_pc_merge;
                    end
                end else begin
                    pend_d     = pend_merge;
                    pend_exc_d = pend_exc_merge;
                    pend_pc_d  = pend_pc_merge;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // Saturating performance counters; clear takes priority over increment.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr_i) begin
            cycle_cnt_d = '0;
            fetch_cnt_d = '0;
            stall_cnt_d = '0;
        end else begin
            if (cycle_cnt_q != '1) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
            if (advance && (fetch_cnt_q != '1)) begin
                fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
            end
            if (fetch_valid && !advance && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State, PC, pending and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StBoot;
            boot_cnt_q  <= '0;
            pc_q        <= RESET_VEC;
            pend_q      <= 1'b0;
            pend_exc_q  <= 1'b0;
            pend_pc_q   <= '0;
            cycle_cnt_q <= '0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_exc_q  <= pend_exc_d;
            pend_pc_q   <= pend_pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_valid_o = fetch_valid;
    assign pc_o          = pc_q;
    assign pc_byte_o     = {pc_q, 2'b00};
    assign pending_o     = pend_q;
    assign state_o       = state_q;
    assign cycle_cnt_o   = cycle_cnt_q;
    assign fetch_cnt_o   = fetch_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule
